// File: rtl/tpm_ram_arbiter_pkg.sv
// Shared types and byte-lane helpers for the TPM buffer RAM arbiter.
package twpm_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OWN_LPC = 1'b0;
  localparam logic OWN_WB  = 1'b1;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [7:0] byte_extract(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/tpm_ram_arbiter_if.sv
// LPC, Wishbone and RAM-side signals of the arbiter; slave = arbiter view.
interface tpm_ram_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              lpc_req_i;
  logic              lpc_we_i;
  logic [ADDR_W+1:0] lpc_addr_i;
  logic [7:0]        lpc_wdata_i;
  logic [7:0]        lpc_rdata_o;
  logic              lpc_ack_o;

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;

  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [3:0]        ram_wen_o;
  logic              ram_wr_en_o;
  logic              ram_rd_en_o;
  logic [31:0]       ram_rdata_i;

  modport slave (
    input  lpc_req_i, lpc_we_i, lpc_addr_i, lpc_wdata_i,
    output lpc_rdata_o, lpc_ack_o,
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o,
    output ram_addr_o, ram_wdata_o, ram_wen_o, ram_wr_en_o, ram_rd_en_o,
    input  ram_rdata_i
  );

  modport master (
    output lpc_req_i, lpc_we_i, lpc_addr_i, lpc_wdata_i,
    input  lpc_rdata_o, lpc_ack_o,
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o,
    input  ram_addr_o, ram_wdata_o, ram_wen_o, ram_wr_en_o, ram_rd_en_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/tpm_ram_arbiter.sv
// Two-requester arbiter (LPC byte / Wishbone word) for the 512x32 TPM buffer RAM.
// Define TWPM_RAM_ARB_STATS_EN to build the contention counter.
module tpm_ram_arbiter
  import twpm_ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int STREAK_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tpm_ram_arbiter_if.slave bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] contention_cnt_o
);

  localparam int STK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STREAK_MAX);

  state_e            state_q, state_d;
  logic              owner_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wen_q;
  logic [1:0]        lane_q;
  logic [STK_W-1:0]  streak_q;

  logic wb_pend, grant_lpc, grant_wb;

  // LPC is favoured until it has won STREAK_MAX times in a row over a waiting WB.
  assign wb_pend   = bus.wb_cyc_i & bus.wb_stb_i;
  assign grant_lpc = bus.lpc_req_i & ~(wb_pend & (streak_q == STK_MAX));
  assign grant_wb  = ~grant_lpc & wb_pend;
  assign busy_o    = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= OWN_LPC;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= '0;
      lane_q   <= '0;
      streak_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_wb) begin
        owner_q  <= OWN_WB;
        we_q     <= bus.wb_we_i;
        addr_q   <= bus.wb_adr_i;
        wdata_q  <= bus.wb_dat_i;
        wen_q    <= bus.wb_sel_i;
        lane_q   <= '0;
        streak_q <= '0;
      end else if (state_q == IDLE && grant_lpc) begin
        owner_q  <= OWN_LPC;
        we_q     <= bus.lpc_we_i;
        addr_q   <= bus.lpc_addr_i[ADDR_W+1:2];
        wdata_q  <= {4{bus.lpc_wdata_i}};
        wen_q    <= lane_mask(bus.lpc_addr_i[1:0]);
        lane_q   <= bus.lpc_addr_i[1:0];
        if (!wb_pend)
          streak_q <= '0;
        else if (streak_q != STK_MAX)
          streak_q <= streak_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = '0;
    bus.ram_wen_o   = '0;
    bus.ram_wr_en_o = 1'b0;
    bus.ram_rd_en_o = 1'b0;
    bus.lpc_ack_o   = 1'b0;
    bus.lpc_rdata_o = '0;
    bus.wb_ack_o    = 1'b0;
    bus.wb_dat_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_lpc || grant_wb) state_d = ACCESS;
      end
      ACCESS: begin
        bus.ram_addr_o  = addr_q;
        bus.ram_rd_en_o = ~we_q;
        // A WB write with no strobes still completes, it just never touches the RAM.
        bus.ram_wr_en_o = we_q & (|wen_q);
        bus.ram_wen_o   = we_q ? wen_q : 4'b0000;
        bus.ram_wdata_o = we_q ? wdata_q : 32'h0;
        state_d         = RESP;
      end
      RESP: begin
        if (owner_q == OWN_LPC && bus.lpc_req_i) begin
          bus.lpc_ack_o   = 1'b1;
          bus.lpc_rdata_o = byte_extract(bus.ram_rdata_i, lane_q);
        end
        if (owner_q == OWN_WB && wb_pend) begin
          bus.wb_ack_o = 1'b1;
          bus.wb_dat_o = bus.ram_rdata_i;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TWPM_RAM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (state_q == IDLE && bus.lpc_req_i && wb_pend && !(&cnt_q))
      cnt_q <= cnt_q + 1'b1;
  end

  assign contention_cnt_o = cnt_q;
`else
  assign contention_cnt_o = '0;
`endif

endmodule
